// File: rtl/arb_mux.sv
// Round-robin arbitrated N-channel valid/ready multiplexer with a single registered output slot.
// Define ARB_MUX_LOCK_EN to hold the grant on a channel until its in_last beat (packet lock).
module arb_mux #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_W:0]   NumCh  = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LastCh = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] ch_data [CHANNELS];

  for (genvar k = 0; k < CHANNELS; k++) begin : g_split
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic             gnt_found;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W:0]   cand;
  logic             xfer;

`ifdef ARB_MUX_LOCK_EN
  logic lock_q, lock_d;
`else
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  assign accept = ~out_valid_q | out_ready;

  // Modular search from ptr; wrap is explicit so CHANNELS need not be a power of two.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cand = {1'b0, ptr_q} + (SEL_W + 1)'(i);
      if (cand >= NumCh) cand = cand - NumCh;
      if (!gnt_found && in_valid[cand[SEL_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[SEL_W-1:0];
      end
    end
`ifdef ARB_MUX_LOCK_EN
    // The locked channel is always the one that supplied the current output beat.
    if (lock_q) begin
      gnt_found = in_valid[out_sel_q];
      gnt_idx   = out_sel_q;
    end
`endif
  end

  assign xfer = accept & gnt_found;

  always_comb begin
    in_ready = '0;
    if (xfer) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = accept ? xfer : out_valid_q;
    ptr_d       = ptr_q;
`ifdef ARB_MUX_LOCK_EN
    lock_d      = lock_q;
`endif
    if (xfer) begin
      out_data_d = ch_data[gnt_idx];
      out_sel_d  = gnt_idx;
`ifdef ARB_MUX_LOCK_EN
      lock_d     = ~in_last[gnt_idx];
      if (in_last[gnt_idx]) ptr_d = (gnt_idx == LastCh) ? '0 : gnt_idx + SEL_W'(1);
`else
      ptr_d      = (gnt_idx == LastCh) ? '0 : gnt_idx + SEL_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
`ifdef ARB_MUX_LOCK_EN
      lock_q      <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
`ifdef ARB_MUX_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: vector table, reset/lock sequences and randomized traffic against a
// round-robin reference model (model follows ARB_MUX_LOCK_EN as the DUT does).
module tb_arb_mux;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [C*W-1:0] in_data;
  logic [C-1:0]   in_valid;
  logic [C-1:0]   in_last;
  logic [C-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  arb_mux #(.WIDTH(W), .CHANNELS(C), .SEL_W(SW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: pointer, locked channel (-1 = none), output slot.
  int           m_ptr;
  int           m_lock;
  logic         m_valid;
  logic [W-1:0] m_data;
  int           m_sel;
  logic [C-1:0] obs_ready;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_lock = -1; m_valid = 1'b0; m_data = '0; m_sel = 0;
  endtask

  function automatic int model_grant(input logic [C-1:0] v);
    if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
    for (int i = 0; i < C; i++) begin
      int k;
      k = (m_ptr + i) % C;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Drives one cycle starting just after a rising edge; returns just after the next one.
  task automatic step(input logic [C-1:0] v, input logic [C*W-1:0] d, input logic [C-1:0] l,
                      input logic r);
    int g;
    bit acc;
    logic [C-1:0] exp_rdy;
    in_valid = v; in_data = d; in_last = l; out_ready = r;
    #1;
    acc = !m_valid || r;
    g = model_grant(v);
    exp_rdy = '0;
    if (acc && g >= 0) exp_rdy[g] = 1'b1;
    obs_ready = in_ready;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (acc) begin
      if (g >= 0) begin
        m_data = d[g*W +: W]; m_sel = g; m_valid = 1'b1;
`ifdef ARB_MUX_LOCK_EN
        if (!l[g]) m_lock = g;
        else begin
          m_lock = -1; m_ptr = (g + 1) % C;
        end
`else
        m_ptr = (g + 1) % C;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("out_sel", 32'(out_sel), 32'(m_sel));
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [C-1:0]   v;
    logic [C*W-1:0] d;
    logic           r;
    logic [C-1:0]   rdy;
    logic           ov;
    logic [W-1:0]   od;
    logic [SW-1:0]  os;
  } vec_t;

  localparam logic [C*W-1:0] Def = 32'hD3C2B1A0;

  vec_t         tbl [15];
  logic [W-1:0] beats [3];
  logic [C-1:0] lasts [3];
  logic [W-1:0] cap_d [4];
  int           cap_s [4];
  logic [W-1:0] exp_d [4];
  int           exp_s [4];

  initial begin
    // Fairness from reset, sparse wrap from ptr=3, idle, then backpressure.
    tbl[0]  = '{4'b1111, Def,          1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[1]  = '{4'b1111, Def,          1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
    tbl[2]  = '{4'b1111, Def,          1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2};
    tbl[3]  = '{4'b1111, Def,          1'b1, 4'b1000, 1'b1, 8'hD3, 2'd3};
    tbl[4]  = '{4'b1111, Def,          1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    tbl[5]  = '{4'b1111, Def,          1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};
    tbl[6]  = '{4'b0100, Def,          1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2};
    tbl[7]  = '{4'b0010, 32'hD3C211A0, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    tbl[8]  = '{4'b1111, Def,          1'b1, 4'b0100, 1'b1, 8'hC2, 2'd2};
    tbl[9]  = '{4'b0000, Def,          1'b1, 4'b0000, 1'b0, 8'hC2, 2'd2};
    tbl[10] = '{4'b0001, 32'hD3C2B1A5, 1'b0, 4'b0001, 1'b1, 8'hA5, 2'd0};
    tbl[11] = '{4'b1111, Def,          1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    tbl[12] = '{4'b1111, Def,          1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    tbl[13] = '{4'b1111, Def,          1'b0, 4'b0000, 1'b1, 8'hA5, 2'd0};
    tbl[14] = '{4'b1111, Def,          1'b1, 4'b0010, 1'b1, 8'hB1, 2'd1};

    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].d, 4'b1111, tbl[i].r);
      check($sformatf("tbl%0d_ready", i), 32'(obs_ready), 32'(tbl[i].rdy));
      check($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      check($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].od));
      check($sformatf("tbl%0d_sel", i), 32'(out_sel), 32'(tbl[i].os));
    end

    // Async reset with a beat held in the slot under backpressure.
    step(4'b1111, Def, 4'b1111, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_data", 32'(out_data), 32'd0);
    check("async_rst_sel", 32'(out_sel), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();

    // Packet from ch2 with a mid-packet stall while ch0 and ch3 keep requesting.
    step(4'b0010, Def, 4'b1111, 1'b1);
    beats = '{8'h20, 8'h21, 8'h22};
    lasts = '{4'b1011, 4'b1011, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      cap_d[i] = 8'hFF; cap_s[i] = -1;
    end
    begin
      int idx2;
      int nb;
      logic ch2v;
      idx2 = 0; nb = 0;
      for (int c = 0; c < 8; c++) begin
        ch2v = (idx2 < 3) && (c != 2);
        step({1'b1, ch2v, 1'b0, 1'b1},
             {8'h3A, (idx2 < 3) ? beats[idx2] : 8'h00, 8'h00, 8'h0A},
             (idx2 < 3) ? lasts[idx2] : 4'b1111, 1'b1);
        if (obs_ready[2]) idx2++;
        if (out_valid && nb < 4) begin
          cap_d[nb] = out_data; cap_s[nb] = int'(out_sel); nb++;
        end
      end
    end
`ifdef ARB_MUX_LOCK_EN
    exp_s = '{2, 2, 2, 3};
    exp_d = '{8'h20, 8'h21, 8'h22, 8'h3A};
`else
    exp_s = '{2, 3, 0, 2};
    exp_d = '{8'h20, 8'h3A, 8'h0A, 8'h21};
`endif
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pkt_beat%0d_sel", i), 32'(cap_s[i]), 32'(exp_s[i]));
      check($sformatf("pkt_beat%0d_data", i), 32'(cap_d[i]), 32'(exp_d[i]));
    end

    // Randomized traffic against the model, with one reset in the middle.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      step(C'($urandom), (C*W)'($urandom), C'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
